// File: rtl/spi_reg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_pkg
// Shared definitions for the SPI register controller: FSM state encoding,
// register map addresses and frame geometry.
// ---------------------------------------------------------------------------
package spi_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_PWM_LO    = 2;
    localparam int unsigned ADDR_PWM_HI    = 3;
    localparam int unsigned ADDR_DUTY      = 4;

    localparam int unsigned FRAME_BITS = 16;
    // Bit counter saturates at FRAME_BITS+1 so an overlong frame stays distinguishable.
    localparam int unsigned CNT_MAX    = FRAME_BITS + 1;
    localparam int unsigned CNT_W      = 5;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for one asynchronous input, plus single-cycle
// rise/fall pulses derived from the last stage and one delay flop.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   d_i      in   asynchronous input
//   sync_o   out  synchronized level (last stage)
//   rise_o   out  one-cycle pulse on synchronized 0->1
//   fall_o   out  one-cycle pulse on synchronized 1->0
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    // Edges are held off until the chain has flushed the reset value, so an
    // input that is already in its non-reset state at release (e.g. ncs low
    // mid-frame) does not look like a fresh edge.
    logic [STAGES:0]   prime_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {STAGES{RST_VAL}};
            dly_q   <= RST_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            dly_q   <= sync_q[STAGES-1];
            prime_q <= {prime_q[STAGES-1:0], 1'b1};
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = prime_q[STAGES] &  sync_q[STAGES-1] & ~dly_q;
    assign fall_o = prime_q[STAGES] & ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// SPI (mode 0) write-only register controller. Receives 16-bit frames
// {rw, addr[6:0], data[7:0]} and writes data into one of NUM_REGS byte
// registers when rw = 1 and the address is in range.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for ncs falling edge
// SHIFT  | collecting bits on sclk rising edges until ncs rises
// COMMIT | one cycle: apply write if valid, then back to IDLE
//
// Ports
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   sclk, ncs, copi  in   asynchronous SPI inputs
//   en_reg_out_7_0   out  register 0x00
//   en_reg_out_15_8  out  register 0x01
//   en_reg_pwm_7_0   out  register 0x02
//   en_reg_pwm_15_8  out  register 0x03
//   pwm_duty_cycle   out  register 0x04
//   wr_strobe        out  pulse when a register write becomes visible
//   frame_err        out  pulse when a frame ends with a count other than 16
// ---------------------------------------------------------------------------
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d_i(ncs),
        .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d_i(copi),
        .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{ncs_s, sclk_s, sclk_fall, copi_rise, copi_fall};

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [7:0]              regs_q [NUM_REGS];
    logic                    wr_strobe_q;
    logic                    frame_err_q;

    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;

    assign wr_addr = shift_q[14:8];
    assign wr_data = shift_q[7:0];
    assign wr_en   = shift_q[15] && (int'(wr_addr) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_q <= ST_SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // ncs rise takes priority; a coincident sclk edge is dropped.
                    if (ncs_rise) begin
                        if (cnt_q == CNT_W'(FRAME_BITS)) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q     <= ST_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                        if (cnt_q != CNT_W'(CNT_MAX)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    if (wr_en) begin
                        wr_strobe_q <= 1'b1;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_addr == 7'(i)) begin
                                regs_q[i] <= wr_data;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    spi_reg_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .ncs            (ncs),
        .copi           (copi),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int ws_cnt       = 0;
    int fe_cnt       = 0;
    logic [7:0] exp_q [5];

    // Pulse counters, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wr_strobe === 1'b1) ws_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    function automatic logic [39:0] regs_now();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] regs_exp();
        return {exp_q[4], exp_q[3], exp_q[2], exp_q[1], exp_q[0]};
    endfunction

    // Shift the low n bits of word MSB first at sclk = clk/4, ncs left low.
    task automatic shift_bits(input int n, input logic [16:0] word, input bit start);
        if (start) begin
            ncs = 1'b0;
            repeat (3) @(negedge clk);
        end
        for (int i = n - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Raise ncs and hold it high for 4 clk; a commit is visible by the return.
    task automatic end_frame();
        repeat (2) @(negedge clk);
        ncs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input logic [16:0] word);
        shift_bits(n, word, 1'b1);
        end_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (regs_now() !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_regs_in_rst: got %h expected %h", regs_now(), 40'h0);
        end
        tests_run++;
        if (wr_strobe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (regs_now() !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_regs_after: got %h expected %h", regs_now(), 40'h0);
        end
        tests_run++;
        if (ws_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_strobe: got %0d expected 0", ws_cnt);
        end
        tests_run++;
        if (fe_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_frame_err: got %0d expected 0", fe_cnt);
        end
    endtask

    task automatic test_single_write();
        int ws0;
        int lat;
        ws0 = ws_cnt;
        lat = 0;
        shift_bits(16, 17'h080A5, 1'b1);
        repeat (2) @(negedge clk);
        ncs = 1'b1;
        // Two sync flops + delay flop put the rise detection in the cycle after
        // the 2nd edge; COMMIT follows, and the write shows after the 4th edge.
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (wr_strobe === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL write_latency: got %0d cycles expected 4", lat);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wr_strobe !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_strobe_width: got %b expected 0", wr_strobe);
        end
        exp_q[0] = 8'hA5;
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL write_a5_regs: got %h expected %h", regs_now(), regs_exp());
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (ws_cnt - ws0 !== 1) begin
            tests_failed++;
            $display("FAIL write_a5_strobe_count: got %0d expected 1", ws_cnt - ws0);
        end
    endtask

    task automatic test_hold();
        int ws0;
        ws0 = ws_cnt;
        send_frame(16, 17'h08480);
        exp_q[4] = 8'h80;
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL hold_duty: got %h expected %h", regs_now(), regs_exp());
        end
        send_frame(16, 17'h0820F);
        exp_q[2] = 8'h0F;
        repeat (20) @(negedge clk);
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL hold_both: got %h expected %h", regs_now(), regs_exp());
        end
        tests_run++;
        if (ws_cnt - ws0 !== 2) begin
            tests_failed++;
            $display("FAIL hold_strobe_count: got %0d expected 2", ws_cnt - ws0);
        end
    endtask

    task automatic test_discard();
        int ws0;
        int fe0;
        ws0 = ws_cnt;
        fe0 = fe_cnt;
        send_frame(16, 17'h001FF);   // read, addr 0x01
        send_frame(16, 17'h08577);   // write, addr 0x05 (first out of range)
        send_frame(16, 17'h0FF11);   // write, addr 0x7F
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL discard_regs: got %h expected %h", regs_now(), regs_exp());
        end
        tests_run++;
        if (ws_cnt - ws0 !== 0) begin
            tests_failed++;
            $display("FAIL discard_strobe: got %0d expected 0", ws_cnt - ws0);
        end
        tests_run++;
        if (fe_cnt - fe0 !== 0) begin
            tests_failed++;
            $display("FAIL discard_frame_err: got %0d expected 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_bad_length();
        int ws0;
        int fe0;
        ws0 = ws_cnt;
        fe0 = fe_cnt;
        send_frame(15, 17'h00111);
        tests_run++;
        if (fe_cnt - fe0 !== 1) begin
            tests_failed++;
            $display("FAIL len15_frame_err: got %0d expected 1", fe_cnt - fe0);
        end
        send_frame(17, 17'h18033);
        tests_run++;
        if (fe_cnt - fe0 !== 2) begin
            tests_failed++;
            $display("FAIL len17_frame_err: got %0d expected 2", fe_cnt - fe0);
        end
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL badlen_regs: got %h expected %h", regs_now(), regs_exp());
        end
        tests_run++;
        if (ws_cnt - ws0 !== 0) begin
            tests_failed++;
            $display("FAIL badlen_strobe: got %0d expected 0", ws_cnt - ws0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ws0;
        int fe0;
        shift_bits(8, 17'h00083, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_q[i] = 8'h00;
        ws0 = ws_cnt;
        fe0 = fe_cnt;
        tests_run++;
        if (regs_now() !== 40'h0) begin
            tests_failed++;
            $display("FAIL midrst_regs_cleared: got %h expected %h", regs_now(), 40'h0);
        end
        shift_bits(8, 17'h000AA, 1'b0);
        end_frame();
        tests_run++;
        if (regs_now() !== 40'h0) begin
            tests_failed++;
            $display("FAIL midrst_tail_regs: got %h expected %h", regs_now(), 40'h0);
        end
        tests_run++;
        if (ws_cnt - ws0 !== 0) begin
            tests_failed++;
            $display("FAIL midrst_tail_strobe: got %0d expected 0", ws_cnt - ws0);
        end
        tests_run++;
        if (fe_cnt - fe0 !== 0) begin
            tests_failed++;
            $display("FAIL midrst_tail_frame_err: got %0d expected 0", fe_cnt - fe0);
        end
        send_frame(16, 17'h0833C);
        exp_q[3] = 8'h3C;
        tests_run++;
        if (regs_now() !== regs_exp()) begin
            tests_failed++;
            $display("FAIL midrst_next_write: got %h expected %h", regs_now(), regs_exp());
        end
        tests_run++;
        if (ws_cnt - ws0 !== 1) begin
            tests_failed++;
            $display("FAIL midrst_next_strobe: got %0d expected 1", ws_cnt - ws0);
        end
    endtask

    task automatic test_back_to_back();
        int ws0;
        logic [6:0] a;
        logic [7:0] d;
        ws0 = ws_cnt;
        for (int f = 0; f < 12; f++) begin
            a = 7'($urandom_range(0, 4));
            d = 8'($urandom_range(0, 255));
            send_frame(16, {1'b0, 1'b1, a, d});
            exp_q[a[2:0]] = d;
            tests_run++;
            if (regs_now() !== regs_exp()) begin
                tests_failed++;
                $display("FAIL b2b_frame%0d addr %0d data %h: got %h expected %h",
                         f, a, d, regs_now(), regs_exp());
            end
        end
        tests_run++;
        if (ws_cnt - ws0 !== 12) begin
            tests_failed++;
            $display("FAIL b2b_strobe_count: got %0d expected 12", ws_cnt - ws0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        for (int i = 0; i < 5; i++) exp_q[i] = 8'h00;
        test_reset();
        test_single_write();
        test_hold();
        test_discard();
        test_bad_length();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the number of flip-flops in each input synchronizer (minimum 2).
REQ-002 The block SHALL have parameter NUM_REGS, default 5, the number of writable registers (addresses 0x00..NUM_REGS-1).
REQ-003 The block SHALL run on one clock; its reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 sclk  in  1  SPI serial clock, asynchronous to clk, mode 0, frequency <= clk/4.
REQ-007 ncs  in  1  SPI chip select, active-low, asynchronous.
REQ-008 copi  in  1  SPI serial data in, MSB first, sampled on sclk rising edge.
REQ-009 en_reg_out_7_0  out  8  register 0x00, output enables for outputs 7..0.
REQ-010 en_reg_out_15_8  out  8  register 0x01, output enables for outputs 15..8.
REQ-011 en_reg_pwm_7_0  out  8  register 0x02, PWM enables for outputs 7..0.
REQ-012 en_reg_pwm_15_8  out  8  register 0x03, PWM enables for outputs 15..8.
REQ-013 pwm_duty_cycle  out  8  register 0x04, PWM duty (0x00 = 0%, 0xFF = 100%).
REQ-014 wr_strobe  out  1  one-cycle pulse in the cycle a register write first becomes visible.
REQ-015 frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 16.

Function
REQ-016 sclk, ncs and copi SHALL each pass through a SYNC_STAGES synchronizer; edge detection SHALL use the last stage and one delay flop.
REQ-017 Frame format SHALL be 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-018 FSM states SHALL be IDLE, SHIFT, COMMIT.
REQ-019 IDLE -> SHIFT on synchronized ncs falling edge; shift register and bit counter cleared.
REQ-020 In SHIFT, each synchronized sclk rising edge SHALL shift synchronized copi into bit0; bit counter increments and saturates at 17.
REQ-021 In SHIFT, on ncs rising edge with count == 16 -> COMMIT; with any other count -> IDLE and frame_err pulses the next cycle.
REQ-022 COMMIT SHALL last exactly one cycle then go to IDLE; it writes data to the addressed register only if bit15 = 1 and address < NUM_REGS.
REQ-023 Read frames (bit15 = 0) and out-of-range addresses SHALL be discarded silently: no register change, no wr_strobe, no frame_err.
REQ-024 Latency: ncs rise edge detected in cycle N -> COMMIT in N+1 -> register value and wr_strobe visible in N+2.
REQ-025 sclk edges while FSM is IDLE or COMMIT SHALL be ignored.
REQ-026 If ncs rise and sclk rise are detected in the same cycle, the ncs edge SHALL win and that sclk edge SHALL not be counted.
REQ-027 A new ncs falling edge during COMMIT SHALL be lost; the master guarantees >= 4 clk of ncs high between frames.
REQ-028 Registers SHALL hold their value between writes; only one register changes per frame.

Reset
REQ-029 On rst: all five registers 0x00, wr_strobe 0, frame_err 0, FSM IDLE, counter 0, shift register 0.
REQ-030 Synchronizer flops for ncs SHALL reset to 1, and for sclk and copi to 0, so reset release with ncs high produces no false edge.
REQ-031 Reset asserted mid-frame SHALL abort the frame; a frame already in progress at reset release SHALL be ignored until the next ncs falling edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the address constants ADDR_EN_OUT_LO..ADDR_DUTY (0x00..0x04) and FRAME_BITS = 16.
REQ-033 One sub-module, sync_edge (synchronizer plus rise/fall pulse outputs), SHALL be instantiated once per SPI input.

Verification
REQ-034 Write 0x00 <- 0xA5 -> en_reg_out_7_0 = 0xA5 and wr_strobe high for one cycle, in cycle N+2 after ncs rise is detected; all other registers 0x00.
REQ-035 Write 0x04 <- 0x80, then 0x02 <- 0x0F -> pwm_duty_cycle = 0x80 and en_reg_pwm_7_0 = 0x0F, both held.
REQ-036 Read frame (bit15 = 0) to 0x01 data 0xFF, and write to address 0x05 -> no register change, no wr_strobe, no frame_err.
REQ-037 Frames of 15 and of 17 sclk pulses -> frame_err pulses once each; registers unchanged.
REQ-038 Assert rst after 8 bits of a write to 0x03 -> all registers 0x00; the rest of that frame produces no write; the next full write to 0x03 <- 0x3C succeeds.
REQ-039 Random back-to-back writes at sclk = clk/4 with ncs gaps of 4 clk -> register file matches the scoreboard after every frame.
